// File: rtl/snn_pkg.sv
// Shared constants and types for the gamma-cycle temporal-coding blocks.
package snn_pkg;

    localparam int TBITS = 3;
    localparam int T_INF = 2**TBITS - 1;

    typedef enum logic [1:0] {IDLE, RUN, WTA, DONE} gamma_state_t;

    typedef logic [TBITS-1:0] spike_time_t;

endpackage

// File: rtl/wta_select.sv
// Combinational min-finder over recorded first-fire times; lowest index wins ties.
module wta_select
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int TBITS       = snn_pkg::TBITS,
    parameter int T_INF       = 2**TBITS - 1,
    parameter int WBITS       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic [NUM_NEURONS-1:0][TBITS-1:0] times,
    output logic [WBITS-1:0]                  winner,
    output logic                              winner_valid
);

    logic [TBITS-1:0] best_time;

    // Strict less-than keeps the earlier (lower) index on equal times.
    always_comb begin
        best_time    = TBITS'(T_INF);
        winner       = '0;
        winner_valid = 1'b0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            if (times[n] != TBITS'(T_INF) && (!winner_valid || times[n] < best_time)) begin
                best_time    = times[n];
                winner       = WBITS'(n);
                winner_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gamma_cycle_scheduler.sv
// Replays one temporal-coded volley over a gamma cycle and records first-fire times.
// Optional winner-take-all inhibition is compiled in with GAMMA_WTA_EN.
module gamma_cycle_scheduler
    import snn_pkg::*;
#(
    parameter int NUM_SPIKES  = 4,
    parameter int NUM_NEURONS = 4,
    parameter int TBITS       = snn_pkg::TBITS,
    parameter int T_INF       = 2**TBITS - 1,
    parameter int T_STEPS     = T_INF,
    parameter int WBITS       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_SPIKES-1:0][TBITS-1:0]  in_times,
    output logic [NUM_SPIKES-1:0]             spikes_to_neurons,
    input  logic [NUM_NEURONS-1:0]            neuron_fire,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_NEURONS-1:0][TBITS-1:0] out_times,
    output logic [WBITS-1:0]                  winner,
    output logic                              winner_valid
);

    gamma_state_t                     state_q, state_d;
    logic [TBITS-1:0]                 step_q, step_d;
    logic [NUM_SPIKES-1:0][TBITS-1:0] times_q, times_d;
    logic [NUM_NEURONS-1:0][TBITS-1:0] rec_q, rec_d;
    logic [NUM_SPIKES-1:0]            spikes_q, spikes_d;
    logic                             out_valid_q, out_valid_d;
    logic [NUM_NEURONS-1:0][TBITS-1:0] out_times_q, out_times_d;
    logic [WBITS-1:0]                 winner_q, winner_d;
    logic                             winner_valid_q, winner_valid_d;

    // Race-logic replay: an input is active from its spike time onward.
    function automatic logic [NUM_SPIKES-1:0] cum_vec(
        input logic [NUM_SPIKES-1:0][TBITS-1:0] t,
        input logic [TBITS-1:0]                 s
    );
        logic [NUM_SPIKES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_SPIKES; i++) begin
            v[i] = (t[i] != TBITS'(T_INF)) && (t[i] <= s);
        end
        return v;
    endfunction

`ifdef GAMMA_WTA_EN
    logic [WBITS-1:0] wta_winner;
    logic             wta_valid;

    wta_select #(
        .NUM_NEURONS (NUM_NEURONS),
        .TBITS       (TBITS),
        .T_INF       (T_INF),
        .WBITS       (WBITS)
    ) u_wta_select (
        .times        (rec_q),
        .winner       (wta_winner),
        .winner_valid (wta_valid)
    );
`endif

    // NOTE: every _d starts from its _q so no path through this block infers a latch.
    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        times_d        = times_q;
        rec_d          = rec_q;
        spikes_d       = spikes_q;
        out_valid_d    = out_valid_q;
        out_times_d    = out_times_q;
        winner_d       = winner_q;
        winner_valid_d = winner_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    times_d  = in_times;
                    step_d   = '0;
                    rec_d    = {NUM_NEURONS{TBITS'(T_INF)}};
                    spikes_d = cum_vec(in_times, '0);
                    state_d  = RUN;
                end
            end
            RUN: begin
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    if (neuron_fire[n] && rec_q[n] == TBITS'(T_INF)) begin
                        rec_d[n] = step_q;
                    end
                end
                if (step_q == TBITS'(T_STEPS - 1)) begin
                    spikes_d = '0;
                    state_d  = WTA;
                end else begin
                    step_d   = step_q + 1'b1;
                    spikes_d = cum_vec(times_q, step_q + 1'b1);
                end
            end
            WTA: begin
`ifdef GAMMA_WTA_EN
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    out_times_d[n] = (wta_valid && wta_winner == WBITS'(n)) ? rec_q[n] : TBITS'(T_INF);
                end
                winner_d       = wta_winner;
                winner_valid_d = wta_valid;
`else
                out_times_d    = rec_q;
                winner_d       = '0;
                winner_valid_d = 1'b0;
`endif
                spikes_d    = '0;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            spikes_q       <= '0;
            out_valid_q    <= 1'b0;
            out_times_q    <= {NUM_NEURONS{TBITS'(T_INF)}};
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            spikes_q       <= spikes_d;
            out_valid_q    <= out_valid_d;
            out_times_q    <= out_times_d;
            winner_q       <= winner_d;
            winner_valid_q <= winner_valid_d;
        end
    end

    // NOTE: working registers are reloaded on every acceptance, so they carry no reset.
    always_ff @(posedge clk) begin
        step_q  <= step_d;
        times_q <= times_d;
        rec_q   <= rec_d;
    end

    assign in_ready          = (state_q == IDLE) && !reset;
    assign spikes_to_neurons = spikes_q;
    assign out_valid         = out_valid_q;
    assign out_times         = out_times_q;
    assign winner            = winner_q;
    assign winner_valid      = winner_valid_q;

endmodule

// File: tb/tb_gamma_cycle_scheduler.sv
// Self-checking bench for gamma_cycle_scheduler; model follows GAMMA_WTA_EN like the DUT.
module tb_gamma_cycle_scheduler;

    localparam int NS    = 4;
    localparam int NN    = 4;
    localparam int TB    = 3;
    localparam int TINF  = 7;
    localparam int STEPS = 7;

    typedef int tarr_t[NS];
    typedef int sarr_t[NN];

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [NS-1:0][TB-1:0]    in_times;
    logic [NS-1:0]            spikes_to_neurons;
    logic [NN-1:0]            neuron_fire;
    logic                     out_valid;
    logic                     out_ready;
    logic [NN-1:0][TB-1:0]    out_times;
    logic [1:0]               winner;
    logic                     winner_valid;

    int checks   = 0;
    int failures = 0;

    gamma_cycle_scheduler #(
        .NUM_SPIKES  (NS),
        .NUM_NEURONS (NN),
        .TBITS       (TB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_times          (in_times),
        .spikes_to_neurons (spikes_to_neurons),
        .neuron_fire       (neuron_fire),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_times         (out_times),
        .winner            (winner),
        .winner_valid      (winner_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs with a real time at or before the step are active.
    function automatic logic [31:0] exp_vec(input tarr_t t, input int s);
        logic [31:0] v = '0;
        for (int i = 0; i < NS; i++) v[i] = (t[i] != TINF) && (t[i] <= s);
        return v;
    endfunction

    // Expected {out_times, winner, winner_valid} from the fire schedules.
    task automatic expect_result(input sarr_t sched, output logic [31:0] ot,
                                 output logic [31:0] w, output logic [31:0] wv);
        int first[NN];
        int best;
        int idx;
        for (int n = 0; n < NN; n++) begin
            first[n] = TINF;
            for (int s = STEPS - 1; s >= 0; s--) if (sched[n][s]) first[n] = s;
        end
        ot = '0;
`ifdef GAMMA_WTA_EN
        best = TINF;
        idx  = 0;
        for (int n = NN - 1; n >= 0; n--) if (first[n] != TINF && first[n] <= best) begin
            best = first[n];
            idx  = n;
        end
        for (int n = 0; n < NN; n++) ot[n*TB +: TB] = (best != TINF && n == idx) ? TB'(first[n]) : TB'(TINF);
        w  = (best != TINF) ? 32'(idx) : 32'd0;
        wv = (best != TINF) ? 32'd1 : 32'd0;
`else
        best = 0;
        idx  = 0;
        for (int n = 0; n < NN; n++) ot[n*TB +: TB] = TB'(first[n]);
        w  = 32'd0;
        wv = 32'd0;
`endif
    endtask

    // Called at #1 after a posedge with the DUT in IDLE; returns #1 after the release edge.
    task automatic do_volley(input tarr_t t, input sarr_t sched, input int hold);
        logic [31:0] ot, w, wv;
        expect_result(sched, ot, w, wv);
        in_valid = 1'b1;
        for (int i = 0; i < NS; i++) in_times[i] = TB'(t[i]);
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int s = 0; s < STEPS; s++) begin
            for (int n = 0; n < NN; n++) neuron_fire[n] = sched[n][s];
            @(negedge clk);
            check($sformatf("spikes_step%0d", s), 32'(spikes_to_neurons), exp_vec(t, s));
            check($sformatf("out_valid_low_step%0d", s), 32'(out_valid), 32'd0);
            check($sformatf("in_ready_low_step%0d", s), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        neuron_fire = '0;
        @(negedge clk);
        check("wta_spikes_zero", 32'(spikes_to_neurons), 32'd0);
        check("wta_out_valid_low", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("out_valid_at_9", 32'(out_valid), 32'd1);
        check("out_times", 32'(out_times), ot);
        check("winner", 32'(winner), w);
        check("winner_valid", 32'(winner_valid), wv);
        check("done_spikes_zero", 32'(spikes_to_neurons), 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            for (int i = 0; i < NS; i++) in_times[i] = TB'(i);
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_times", 32'(out_times), ot);
            check("bp_winner", 32'(winner), w);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        tarr_t t;
        sarr_t sc;
        logic [31:0] all_inf = 32'hFFF;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_times = '0; neuron_fire = '0;

        // Reset and idle
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_out_times", 32'(out_times), all_inf);
        check("idle_spikes", 32'(spikes_to_neurons), 32'd0);
        check("idle_winner", 32'(winner), 32'd0);
        check("idle_winner_valid", 32'(winner_valid), 32'd0);
        @(posedge clk); #1;

        // Single volley: neuron 1 at step 2, neuron 3 at step 4 (refires ignored)
        t  = '{0, 2, 7, 5};
        sc = '{0, 32'b0010100, 0, 32'b1110000};
        do_volley(t, sc, 0);

        // Tie at step 3 between neurons 1 and 2
        t  = '{1, 3, 6, 0};
        sc = '{0, 32'b1001000, 32'b0101000, 0};
        do_volley(t, sc, 0);

        // No input spikes, no fires
        t  = '{7, 7, 7, 7};
        sc = '{0, 0, 0, 0};
        do_volley(t, sc, 0);

        // Backpressure with a competing volley held on in_valid
        t  = '{4, 0, 6, 2};
        sc = '{32'b1000000, 32'b0000001, 0, 32'b0100000};
        do_volley(t, sc, 5);

        // Mid-run reset at step 3
        t = '{0, 1, 2, 3};
        in_valid = 1'b1;
        for (int i = 0; i < NS; i++) in_times[i] = TB'(t[i]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            neuron_fire = 4'b0001;
            @(negedge clk);
            check($sformatf("abort_spikes_step%0d", s), 32'(spikes_to_neurons), exp_vec(t, s));
            if (s < 3) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        neuron_fire = '0;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_spikes", 32'(spikes_to_neurons), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_times", 32'(out_times), all_inf);
        check("abort_winner_valid", 32'(winner_valid), 32'd0);
        @(posedge clk); #1;
        t  = '{5, 7, 1, 3};
        sc = '{0, 0, 32'b0010000, 32'b0000100};
        do_volley(t, sc, 1);

        // Randomized volleys
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NS; i++) t[i] = $urandom_range(0, 7);
            for (int n = 0; n < NN; n++) sc[n] = $urandom_range(0, 127) & $urandom_range(0, 127);
            do_volley(t, sc, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
